// File: rtl/mux_reg_arbiter.sv
// Two-requester arbiter feeding one output register, with burst-limited
// ownership so a busy requester cannot starve the other.
module mux_reg_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req0,
  input  logic [DATA_W-1:0]                  d0,
  input  logic                               req1,
  input  logic [DATA_W-1:0]                  d1,
  output logic                               gnt0,
  output logic                               gnt1,
  output logic                               sel,
  output logic [DATA_W-1:0]                  q,
  output logic                               q_valid,
  input  logic                               q_ready,
  output logic [1:0]                         state_o,
  output logic                               last_owner_o,
  output logic [$clog2(MAX_BURST+1)-1:0]     burst_cnt_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Handshake: the register slot accepts new data in any cycle where it is
  // empty or the consumer takes it (q_valid && q_ready); a grant is the only
  // way data enters the slot, and q_ready is ignored while q_valid is low.

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                last_owner_q, last_owner_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;

  logic                slot_free;
  logic                own_req;
  logic                oth_req;
  logic                cur_id;
  state_e              oth_state;
  logic [CNT_W-1:0]    cnt_inc;

  assign slot_free = !q_valid_q || q_ready;
  assign gnt0      = (state_q == OWN0) && req0 && slot_free;
  assign gnt1      = (state_q == OWN1) && req1 && slot_free;

  // View of the current owner's side, so OWN0/OWN1 share one decision path.
  assign cur_id    = (state_q == OWN1);
  assign own_req   = cur_id ? req1 : req0;
  assign oth_req   = cur_id ? req0 : req1;
  assign oth_state = cur_id ? OWN0 : OWN1;
  assign cnt_inc   = burst_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (slot_free) begin
          if (!own_req) begin
            last_owner_d = cur_id;
            state_d      = oth_req ? oth_state : IDLE;
          end else if (cnt_inc == MAX_CNT) begin
            // Burst exhausted: hand over if the other side waits, else restart.
            burst_cnt_d = '0;
            if (oth_req) begin
              state_d      = oth_state;
              last_owner_d = cur_id;
            end
          end else begin
            burst_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end
  end

  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    if (gnt0 || gnt1) begin
      q_d       = gnt1 ? d1 : d0;
      q_valid_d = 1'b1;
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      q_q          <= '0;
      q_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
    end
  end

  assign sel          = (state_q == OWN1);
  assign q            = q_q;
  assign q_valid      = q_valid_q;
  assign state_o      = state_q;
  assign last_owner_o = last_owner_q;
  assign burst_cnt_o  = burst_cnt_q;

endmodule

// File: tb/tb_mux_reg_arbiter.sv
// Bench for mux_reg_arbiter: directed scenarios plus a randomized run
// against a cycle-level ownership model and an expected-data queue.
module tb_mux_reg_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic              clk;
  logic              rst;
  logic              req0, req1;
  logic [DATA_W-1:0] d0, d1;
  logic              gnt0, gnt1, sel;
  logic [DATA_W-1:0] q;
  logic              q_valid, q_ready;
  logic [1:0]        state_o;
  logic              last_owner_o;
  logic [CNT_W-1:0]  burst_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner is -1 when nobody owns the register, else 0/1.
  int                m_owner;
  int                m_cnt;
  int                m_last;
  logic [DATA_W-1:0] m_q;
  bit                m_v;
  logic [DATA_W-1:0] exp_q[$];

  mux_reg_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .state_o(state_o), .last_owner_o(last_owner_o), .burst_cnt_o(burst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1;
    m_q     = '0;
    m_v     = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_advance();
    bit slot, rx, ry, g0, g1;
    slot = !m_v || q_ready;
    g0   = (m_owner == 0) && req0 && slot;
    g1   = (m_owner == 1) && req1 && slot;
    if (m_owner < 0) begin
      if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
      m_cnt = 0;
    end else if (slot) begin
      rx = (m_owner == 1) ? req1 : req0;
      ry = (m_owner == 1) ? req0 : req1;
      if (!rx) begin
        m_last  = m_owner;
        m_owner = ry ? 1 - m_owner : -1;
        m_cnt   = 0;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MAX_BURST) begin
          m_cnt = 0;
          if (ry) begin
            m_last  = m_owner;
            m_owner = 1 - m_owner;
          end
        end
      end
    end
    if (g0 || g1) begin
      m_q = g1 ? d1 : d0;
      m_v = 1'b1;
    end else if (m_v && q_ready) begin
      m_v = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; q_ready = 1'b0; d0 = '0; d1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; q_ready = 1'b1; d0 = 8'h11; d1 = 8'h22;
    model_reset();
    @(negedge clk); #1;
    n_checks++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
    n_checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b want 0", q_valid); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel); else n_pass++;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); else n_pass++;
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL release_no_gnt: got %b%b want 00", gnt0, gnt1); else n_pass++;
    tick(); #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL first_tie_req0: got %b%b want 10", gnt0, gnt1); else n_pass++;
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req0 = 1'b1; d0 = 8'hA5; q_ready = 1'b1; #1;
    n_checks++; if (gnt0 !== 1'b0) $display("FAIL single_idle_gnt0: got %b want 0", gnt0); else n_pass++;
    tick(); #1;
    n_checks++; if (gnt0 !== 1'b1) $display("FAIL single_gnt0: got %b want 1", gnt0); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL single_sel: got %b want 0", sel); else n_pass++;
    tick();
    req0 = 1'b0; #1;
    n_checks++; if (q !== 8'hA5) $display("FAIL single_q: got %h want a5", q); else n_pass++;
    n_checks++; if (q_valid !== 1'b1) $display("FAIL single_q_valid: got %b want 1", q_valid); else n_pass++;
    tick();
  endtask

  task automatic test_tie();
    bit e0;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; q_ready = 1'b1; #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL tie_idle: got %b%b want 00", gnt0, gnt1); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      d0 = DATA_W'($urandom); d1 = DATA_W'($urandom); #1;
      e0 = (((i - 1) / MAX_BURST) % 2) == 0;
      n_checks++;
      if ({gnt0, gnt1} !== {e0, !e0})
        $display("FAIL tie_cycle%0d: got gnt %b%b want %b%b", i, gnt0, gnt1, e0, !e0);
      else n_pass++;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] want;
    apply_reset();
    held = '0;
    for (int i = 0; i < 25; i++) begin
      d0 = DATA_W'($urandom);
      q_ready = (i < 4) || (i >= 14);
      req0 = (i < 20);
      #1;
      if (q_valid && q_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_unexpected: got q %h want nothing", q);
        else begin
          want = exp_q.pop_front();
          if (q !== want) $display("FAIL bp_data: got %h want %h", q, want); else n_pass++;
        end
      end
      if (i == 4) begin
        held = q;
        n_checks++; if (q_valid !== 1'b1) $display("FAIL bp_stall_valid: got %b want 1", q_valid); else n_pass++;
      end
      if (i >= 4 && i < 14) begin
        n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL bp_stall_gnt: got %b%b want 00", gnt0, gnt1); else n_pass++;
      end
      if (i >= 5 && i <= 14) begin
        n_checks++; if (q !== held) $display("FAIL bp_stall_q: got %h want %h", q, held); else n_pass++;
      end
      if (gnt0) exp_q.push_back(d0);
      tick();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (q_valid !== 1'b0) $display("FAIL bp_final_valid: got %b want 0", q_valid); else n_pass++;
  endtask

  task automatic test_lone_owner();
    apply_reset();
    req1 = 1'b1; q_ready = 1'b1; #1;
    n_checks++; if (gnt1 !== 1'b0) $display("FAIL lone_idle_gnt1: got %b want 0", gnt1); else n_pass++;
    for (int i = 1; i <= 12; i++) begin
      tick();
      d1 = DATA_W'($urandom); #1;
      n_checks++;
      if ({gnt1, sel} !== 2'b11) $display("FAIL lone_cycle%0d: got gnt1 %b sel %b want 1 1", i, gnt1, sel);
      else n_pass++;
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req1 = 1'b1; q_ready = 1'b1; d1 = 8'h5A;
    repeat (3) tick();
    q_ready = 1'b0; #1;
    n_checks++; if ({sel, q_valid} !== 2'b11) $display("FAIL rmb_pre: got sel %b valid %b want 1 1", sel, q_valid); else n_pass++;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (q !== 8'h00) $display("FAIL rmb_q: got %h want 00", q); else n_pass++;
    n_checks++; if (q_valid !== 1'b0) $display("FAIL rmb_valid: got %b want 0", q_valid); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL rmb_sel: got %b want 0", sel); else n_pass++;
    req0 = 1'b1; req1 = 1'b1; q_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL rmb_release: got %b%b want 00", gnt0, gnt1); else n_pass++;
    tick(); #1;
    n_checks++; if ({gnt0, gnt1, sel} !== 3'b100) $display("FAIL rmb_first_own0: got gnt %b%b sel %b want 10 0", gnt0, gnt1, sel); else n_pass++;
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_handover();
    apply_reset();
    req0 = 1'b1; q_ready = 1'b1; d0 = 8'h3C; d1 = 8'hC3;
    tick(); #1;
    n_checks++; if (gnt0 !== 1'b1) $display("FAIL ho_gnt0: got %b want 1", gnt0); else n_pass++;
    tick();
    req0 = 1'b0; req1 = 1'b1; #1;
    n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL ho_switch_cycle: got %b%b want 00", gnt0, gnt1); else n_pass++;
    tick(); #1;
    n_checks++; if ({gnt1, sel} !== 2'b11) $display("FAIL ho_gnt1: got gnt1 %b sel %b want 1 1", gnt1, sel); else n_pass++;
    tick(); #1;
    n_checks++; if (q !== 8'hC3) $display("FAIL ho_q: got %h want c3", q); else n_pass++;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit slot, e0, e1;
    logic [DATA_W-1:0] want;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      d0 = DATA_W'($urandom);
      d1 = DATA_W'($urandom);
      q_ready = ($urandom_range(0, 3) != 0);
      #1;
      slot = !m_v || q_ready;
      e0 = (m_owner == 0) && req0 && slot;
      e1 = (m_owner == 1) && req1 && slot;
      n_checks++;
      if ({gnt0, gnt1} !== {e0, e1}) $display("FAIL rnd_gnt@%0d: got %b%b want %b%b", i, gnt0, gnt1, e0, e1);
      else n_pass++;
      n_checks++;
      if (sel !== (m_owner == 1)) $display("FAIL rnd_sel@%0d: got %b want %b", i, sel, (m_owner == 1));
      else n_pass++;
      n_checks++;
      if ({q_valid, q} !== {m_v, m_q}) $display("FAIL rnd_q@%0d: got %b/%h want %b/%h", i, q_valid, q, m_v, m_q);
      else n_pass++;
      n_checks++;
      if (int'(burst_cnt_o) > MAX_BURST) $display("FAIL rnd_burst@%0d: got %0d want <=%0d", i, burst_cnt_o, MAX_BURST);
      else n_pass++;
      if (q_valid && q_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_unexpected@%0d: got q %h want nothing", i, q);
        else begin
          want = exp_q.pop_front();
          if (q !== want) $display("FAIL rnd_data@%0d: got %h want %h", i, q, want); else n_pass++;
        end
      end
      if (e0) exp_q.push_back(d0);
      if (e1) exp_q.push_back(d1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; q_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_lone_owner();
    test_reset_mid_burst();
    test_handover();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
